// File: rtl/cond_flag_pkg.sv
// Shared condition-code encodings, flag bit positions and the branch
// condition evaluator used by the flag/branch unit.
package cond_flag_pkg;

   localparam logic [3:0] COND_EQ = 4'd0;
   localparam logic [3:0] COND_NE = 4'd1;
   localparam logic [3:0] COND_GT = 4'd2;
   localparam logic [3:0] COND_LT = 4'd3;
   localparam logic [3:0] COND_GE = 4'd4;
   localparam logic [3:0] COND_LE = 4'd5;
   localparam logic [3:0] COND_OV = 4'd6;
   localparam logic [3:0] COND_AL = 4'd7;
   localparam logic [3:0] COND_CS = 4'd8;
   localparam logic [3:0] COND_CC = 4'd9;
   localparam logic [3:0] COND_MI = 4'd10;
   localparam logic [3:0] COND_PL = 4'd11;
   localparam logic [3:0] COND_RSV_LO = 4'd12;
   localparam logic [3:0] COND_RSV_HI = 4'd15;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_C = 0;

   function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
      logic n, z, v, c, r;
      n = f[FLAG_N];
      z = f[FLAG_Z];
      v = f[FLAG_V];
      c = f[FLAG_C];
      case (cond)
         COND_EQ: r = z;
         COND_NE: r = ~z;
         COND_GT: r = ~z & ~n & ~v;
         COND_LT: r = n & ~v;
         COND_GE: r = ~n & ~v;
         COND_LE: r = (n & ~v) | z;
         COND_OV: r = v;
         COND_AL: r = 1'b1;
         COND_CS: r = c;
         COND_CC: r = ~c;
         COND_MI: r = n;
         COND_PL: r = ~n;
         default: r = 1'b0;  // reserved codes are never taken
      endcase
      return r;
   endfunction

endpackage

// File: rtl/cond_flag_unit_flag_stack.sv
// LIFO of 4-bit flag snapshots for interrupt entry/exit, with a sticky
// error flag for illegal push/pop combinations.
module flag_stack #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic       pop,
   input  logic [3:0] din,
   output logic [3:0] tos,
   output logic       pop_done,
   output logic       full,
   output logic       empty,
   output logic       err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             err_reg, err_next;
   logic [3:0]       entry_reg [DEPTH];
   logic [PTR_W-1:0] top_idx;
   logic             push_ok;

   assign full     = (cnt_reg == CNT_W'(DEPTH));
   assign empty    = (cnt_reg == '0);
   assign err      = err_reg;
   assign push_ok  = push & ~pop & ~full;
   assign pop_done = pop & ~push & ~empty;
   assign top_idx  = PTR_W'(cnt_reg - CNT_W'(1));
   assign tos      = entry_reg[top_idx];

   always_comb begin
      cnt_next = cnt_reg;
      if (push_ok)
         cnt_next = cnt_reg + CNT_W'(1);
      else if (pop_done)
         cnt_next = cnt_reg - CNT_W'(1);
      err_next = err_reg | (push & pop) | (push & full) | (pop & empty);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_reg <= '0;
         err_reg <= 1'b0;
      end else begin
         cnt_reg <= cnt_next;
         err_reg <= err_next;
      end
   end

   // Entry contents need no reset: a zero count makes them unreachable.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (push_ok && (cnt_reg[PTR_W-1:0] == PTR_W'(gi)))
               entry_reg[gi] <= din;
         end
      end
   endgenerate

endmodule

// File: rtl/cond_flag_unit.sv
// Flag register, branch-condition resolution with valid/ready result
// handshake, and interrupt flag save/restore.
module cond_flag_unit
   import cond_flag_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int STACK_DEPTH = 4,
   parameter int FWD_EN      = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flag_we,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_v,
   input  logic              alu_c,
   input  logic              br_valid,
   input  logic [3:0]        br_cond,
   output logic              br_ready,
   output logic              res_valid,
   output logic              res_taken,
   input  logic              res_ready,
   input  logic              push,
   input  logic              pop,
   output logic              stk_full,
   output logic              stk_empty,
   output logic              stk_err,
   output logic [3:0]        flags
);

   logic [3:0] flags_reg;
   logic [3:0] nxt_flags;
   logic [3:0] eff_flags;
   logic [3:0] stk_tos;
   logic       stk_pop_done;
   logic       res_valid_reg, res_taken_reg;
   logic       accept;

   assign nxt_flags = {alu_result[DATA_W-1], (alu_result == '0), alu_v, alu_c};
   assign eff_flags = ((FWD_EN != 0) && flag_we) ? nxt_flags : flags_reg;

   // A pop in flight owns the flag register, so branches stall that cycle.
   assign br_ready  = ~pop & (~res_valid_reg | res_ready);
   assign accept    = br_valid & br_ready;

   assign flags     = flags_reg;
   assign res_valid = res_valid_reg;
   assign res_taken = res_taken_reg;

   flag_stack #(
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .pop      (pop),
      .din      (eff_flags),
      .tos      (stk_tos),
      .pop_done (stk_pop_done),
      .full     (stk_full),
      .empty    (stk_empty),
      .err      (stk_err)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flags_reg     <= 4'b0000;
         res_valid_reg <= 1'b0;
         res_taken_reg <= 1'b0;
      end else begin
         if (stk_pop_done)
            flags_reg <= stk_tos;
         else if (flag_we)
            flags_reg <= nxt_flags;

         if (accept) begin
            res_valid_reg <= 1'b1;
            res_taken_reg <= cond_eval(br_cond, eff_flags);
         end else if (res_ready) begin
            res_valid_reg <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Randomised and directed bench for cond_flag_unit; one instance with
// forwarding and one without, both checked against a behavioural model.
module tb_cond_flag_unit;

   logic        clk = 1'b0;
   logic        rst_n, flag_we, alu_v, alu_c, br_valid, res_ready, push, pop;
   logic [15:0] alu_result;
   logic [3:0]  br_cond;

   logic [3:0]  d_flags [2];
   logic        d_brdy [2], d_rv [2], d_rt [2], d_full [2], d_empty [2], d_err [2];

   // model state, index 0 = FWD_EN 0, index 1 = FWD_EN 1
   logic [3:0]  m_flags [2];
   logic [3:0]  m_stk [2][4];
   int          m_cnt [2];
   logic        m_rv [2], m_rt [2], m_err [2];

   int n_vec = 0, n_cmp = 0, n_fail = 0;

   always #5 clk = ~clk;

   cond_flag_unit #(.DATA_W(16), .STACK_DEPTH(4), .FWD_EN(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .alu_result(alu_result),
      .alu_v(alu_v), .alu_c(alu_c), .br_valid(br_valid), .br_cond(br_cond),
      .br_ready(d_brdy[0]), .res_valid(d_rv[0]), .res_taken(d_rt[0]),
      .res_ready(res_ready), .push(push), .pop(pop), .stk_full(d_full[0]),
      .stk_empty(d_empty[0]), .stk_err(d_err[0]), .flags(d_flags[0]));

   cond_flag_unit #(.DATA_W(16), .STACK_DEPTH(4), .FWD_EN(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .alu_result(alu_result),
      .alu_v(alu_v), .alu_c(alu_c), .br_valid(br_valid), .br_cond(br_cond),
      .br_ready(d_brdy[1]), .res_valid(d_rv[1]), .res_taken(d_rt[1]),
      .res_ready(res_ready), .push(push), .pop(pop), .stk_full(d_full[1]),
      .stk_empty(d_empty[1]), .stk_err(d_err[1]), .flags(d_flags[1]));

   function automatic logic ref_cond(input int code, input logic [3:0] f);
      logic n, z, v, c;
      {n, z, v, c} = f;
      if (code == 0)  return z;
      if (code == 1)  return !z;
      if (code == 2)  return !z && !n && !v;
      if (code == 3)  return n && !v;
      if (code == 4)  return !n && !v;
      if (code == 5)  return (n && !v) || z;
      if (code == 6)  return v;
      if (code == 7)  return 1'b1;
      if (code == 8)  return c;
      if (code == 9)  return !c;
      if (code == 10) return n;
      if (code == 11) return !n;
      return 1'b0;
   endfunction

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      for (int m = 0; m < 2; m++) begin
         logic [3:0] nxt, eff;
         logic       rdy, popped;
         nxt = {alu_result[15], alu_result == 16'h0, alu_v, alu_c};
         eff = (m == 1 && flag_we) ? nxt : m_flags[m];
         rdy = !pop && (!m_rv[m] || res_ready);
         popped = 1'b0;
         if (!rst_n) begin
            m_flags[m] = 4'h0; m_cnt[m] = 0; m_rv[m] = 0; m_rt[m] = 0; m_err[m] = 0;
         end else begin
            if (br_valid && rdy) begin
               m_rv[m] = 1'b1;
               m_rt[m] = ref_cond(int'(br_cond), eff);
            end else if (res_ready) begin
               m_rv[m] = 1'b0;
            end
            if (push && pop) m_err[m] = 1'b1;
            else if (push) begin
               if (m_cnt[m] == 4) m_err[m] = 1'b1;
               else begin m_stk[m][m_cnt[m]] = eff; m_cnt[m]++; end
            end else if (pop) begin
               if (m_cnt[m] == 0) m_err[m] = 1'b1;
               else begin m_cnt[m]--; m_flags[m] = m_stk[m][m_cnt[m]]; popped = 1'b1; end
            end
            if (!popped && flag_we) m_flags[m] = nxt;
         end
      end
   endtask

   // Compare every output with the model, then advance one clock.
   task automatic tick();
      #1;
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("flags[fwd%0d]", m), d_flags[m], m_flags[m]);
         chk($sformatf("res_valid[fwd%0d]", m), {3'b0, d_rv[m]}, {3'b0, m_rv[m]});
         if (m_rv[m])
            chk($sformatf("res_taken[fwd%0d]", m), {3'b0, d_rt[m]}, {3'b0, m_rt[m]});
         chk($sformatf("br_ready[fwd%0d]", m), {3'b0, d_brdy[m]},
             {3'b0, !pop && (!m_rv[m] || res_ready)});
         chk($sformatf("stk_full[fwd%0d]", m), {3'b0, d_full[m]}, {3'b0, m_cnt[m] == 4});
         chk($sformatf("stk_empty[fwd%0d]", m), {3'b0, d_empty[m]}, {3'b0, m_cnt[m] == 0});
         chk($sformatf("stk_err[fwd%0d]", m), {3'b0, d_err[m]}, {3'b0, m_err[m]});
      end
      @(posedge clk);
      model_step();
      n_vec++;
      @(negedge clk);
   endtask

   task automatic idle();
      flag_we = 0; alu_result = 16'h1234; alu_v = 0; alu_c = 0;
      br_valid = 0; br_cond = 4'd0; res_ready = 1; push = 0; pop = 0;
   endtask

   initial begin
      rst_n = 0;
      idle();
      @(negedge clk);
      tick();
      rst_n = 1;
      tick();
      chk("reset_flags", d_flags[1], 4'b0000);
      chk("reset_empty", {3'b0, d_empty[1]}, 4'd1);
      chk("reset_rv", {3'b0, d_rv[1]}, 4'd0);
      chk("reset_brdy", {3'b0, d_brdy[1]}, 4'd1);
      chk("reset_err", {3'b0, d_err[1]}, 4'd0);

      // zero result with carry, then EQ
      flag_we = 1; alu_result = 16'h0000; alu_v = 0; alu_c = 1;
      tick();
      flag_we = 0; br_valid = 1; br_cond = 4'd0;
      tick();
      br_valid = 0;
      chk("eq_flags", d_flags[1], 4'b0101);
      chk("eq_rv", {3'b0, d_rv[1]}, 4'd1);
      chk("eq_taken", {3'b0, d_rt[1]}, 4'd1);

      // same-cycle flag write and LT
      flag_we = 1; alu_result = 16'h8000; alu_v = 0; alu_c = 0;
      br_valid = 1; br_cond = 4'd3;
      tick();
      flag_we = 0; br_valid = 0;
      chk("lt_fwd_taken", {3'b0, d_rt[1]}, 4'd1);
      chk("lt_nofwd_taken", {3'b0, d_rt[0]}, 4'd0);

      // backpressure then back-to-back
      br_valid = 1; br_cond = 4'd7;
      tick();
      res_ready = 0; br_cond = 4'd0;
      for (int i = 0; i < 3; i++) begin
         #1 chk("bp_brdy", {3'b0, d_brdy[1]}, 4'd0);
         tick();
         chk("bp_taken_stable", {3'b0, d_rt[1]}, 4'd1);
         chk("bp_rv", {3'b0, d_rv[1]}, 4'd1);
      end
      res_ready = 1;
      tick();
      chk("b2b_rv0", {3'b0, d_rv[1]}, 4'd1);
      chk("b2b_taken0", {3'b0, d_rt[1]}, 4'd0);
      br_cond = 4'd7;
      tick();
      chk("b2b_rv1", {3'b0, d_rv[1]}, 4'd1);
      chk("b2b_taken1", {3'b0, d_rt[1]}, 4'd1);
      br_valid = 0;
      tick();
      chk("drain_rv", {3'b0, d_rv[1]}, 4'd0);

      // stack save/restore, flags currently 1000
      push = 1;
      tick();
      push = 0; flag_we = 1; alu_result = 16'h0000; alu_c = 0;
      tick();
      flag_we = 0; push = 1;
      tick();
      push = 0; pop = 1;
      tick();
      chk("pop1_flags", d_flags[1], 4'b0100);
      tick();
      chk("pop2_flags", d_flags[1], 4'b1000);
      chk("pop2_empty", {3'b0, d_empty[1]}, 4'd1);
      tick();
      chk("underflow_err", {3'b0, d_err[1]}, 4'd1);
      chk("underflow_flags", d_flags[1], 4'b1000);
      pop = 0;

      // fill, overflow, pop beats flag_we, reset
      rst_n = 0;
      tick();
      rst_n = 1;
      for (int i = 0; i < 4; i++) begin
         flag_we = 1; alu_result = 16'h8000; alu_v = i[0]; alu_c = i[1]; push = 1;
         tick();
      end
      chk("fill_full", {3'b0, d_full[1]}, 4'd1);
      chk("fill_err", {3'b0, d_err[1]}, 4'd0);
      flag_we = 0;
      tick();
      chk("overflow_err", {3'b0, d_err[1]}, 4'd1);
      chk("overflow_full", {3'b0, d_full[1]}, 4'd1);
      push = 0; pop = 1; flag_we = 1; alu_result = 16'h0000; alu_v = 0; alu_c = 0;
      tick();
      chk("pop_wins", d_flags[1], 4'b1011);
      idle();
      rst_n = 0;
      tick();
      chk("rst_flags", d_flags[1], 4'b0000);
      chk("rst_empty", {3'b0, d_empty[1]}, 4'd1);
      chk("rst_full", {3'b0, d_full[1]}, 4'd0);
      chk("rst_err", {3'b0, d_err[1]}, 4'd0);
      chk("rst_rv", {3'b0, d_rv[1]}, 4'd0);
      chk("rst_rt", {3'b0, d_rt[1]}, 4'd0);
      rst_n = 1;

      // randomised traffic
      for (int i = 0; i < 3000; i++) begin
         rst_n      = ($urandom_range(0, 99) != 0);
         flag_we    = $urandom_range(0, 1) == 1;
         case ($urandom_range(0, 3))
            0: alu_result = 16'h0000;
            1: alu_result = 16'h8000 | 16'($urandom);
            default: alu_result = 16'($urandom);
         endcase
         alu_v      = $urandom_range(0, 1) == 1;
         alu_c      = $urandom_range(0, 1) == 1;
         br_valid   = $urandom_range(0, 1) == 1;
         br_cond    = 4'($urandom_range(0, 15));
         res_ready  = $urandom_range(0, 3) != 0;
         push       = $urandom_range(0, 4) == 0;
         pop        = $urandom_range(0, 4) == 0;
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/cond_flag_unit.md
Name: cond_flag_unit

Overview:
Parametrised successor to the processor's flag register and branch-condition logic. It derives N/Z/V/C from the ALU result, holds them in a flag register, and resolves branch conditions. Resolution uses a valid/ready handshake with a registered result, same-cycle flag forwarding, and an extended 4-bit condition set. A LIFO flag stack saves and restores flags on interrupt entry and exit. The block sits between the execute stage (ALU) and the fetch/PC-select logic.

Parameters:
DATA_W, 16, ALU result width; Z is computed over all DATA_W bits and N is bit DATA_W-1.
STACK_DEPTH, 4, number of flag-stack entries; must be a power of two and at least 2.
FWD_EN, 1, 1 = a branch evaluated in the same cycle as flag_we sees the new flags; 0 = it sees the registered flags.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  synchronous active-low reset.
flag_we  in  1  execute stage wrote flags this cycle (ADD/SUB/NAND/XOR/INC class).
alu_result  in  DATA_W  ALU result used to compute N and Z.
alu_v  in  1  ALU signed overflow.
alu_c  in  1  ALU carry out.
br_valid  in  1  branch request.
br_cond  in  4  condition code for the request.
br_ready  out  1  unit can accept a request this cycle.
res_valid  out  1  registered branch result is valid.
res_taken  out  1  branch is taken; meaningful only while res_valid is high.
res_ready  in  1  consumer accepts the result.
push  in  1  save flags (interrupt entry).
pop  in  1  restore flags (interrupt return).
stk_full  out  1  stack holds STACK_DEPTH entries.
stk_empty  out  1  stack holds 0 entries.
stk_err  out  1  sticky error flag, cleared only by reset.
flags  out  4  registered flags {N,Z,V,C}.

Behaviour:
- Reset, when rst_n is low at a rising edge:
  - flags = 0, stack count = 0, res_valid = 0, res_taken = 0, stk_err = 0.
  - stk_empty = 1, stk_full = 0.
- Flag computation:
  - nxt_flags = {alu_result[DATA_W-1], (alu_result==0), alu_v, alu_c}.
  - Flags load nxt_flags on a clk edge when flag_we is high; otherwise they hold.
- Effective flags for evaluation: eff = (FWD_EN && flag_we) ? nxt_flags : flags.
- Condition encoding:
  - 0 EQ: Z.
  - 1 NE: ~Z.
  - 2 GT: ~Z & ~N & ~V.
  - 3 LT: N & ~V.
  - 4 GE: ~N & ~V.
  - 5 LE: (N & ~V) | Z.
  - 6 OV: V.
  - 7 AL: 1.
  - 8 CS: C.
  - 9 CC: ~C.
  - 10 MI: N.
  - 11 PL: ~N.
  - 12-15 reserved: evaluate to 0 (never taken).
- Branch handshake:
  - br_ready = ~pop & (~res_valid | res_ready).
  - A request is accepted when br_valid & br_ready. On acceptance, res_valid = 1 and res_taken = cond(eff) at the next edge, giving 1-cycle latency.
  - Result handshake: when res_valid & res_ready and no new acceptance, res_valid clears. An accepted request and a consumed result in the same cycle keep res_valid at 1 with the new value (back-to-back throughput of 1 per cycle).
  - While res_valid is high and res_ready is low, res_taken holds stable.
- Flag stack:
  - push: if not full and pop is low, write eff into entry[count] and count++. eff includes forwarded flags when flag_we is high in the same cycle and FWD_EN=1.
  - pop: if not empty and push is low, flags <= entry[count-1] and count--. Pop has priority over flag_we: that cycle's flag_we update is discarded.
  - Push and pop together: both are ignored and stk_err is set.
  - Push when full or pop when empty: the operation is ignored, state is unchanged, and stk_err is set.
  - stk_full and stk_empty are derived combinationally from the registered count.
- Reset mid-operation: a pending result and all stack contents are discarded; the reset values above apply on the next cycle.

Decomposition:
- Package cond_flag_pkg:
  - condition-code localparams (EQ..PL, reserved range);
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_V=1, FLAG_C=0;
  - function cond_eval(cond, flags).
- Sub-module flag_stack: parametrised LIFO (entry width 4, depth STACK_DEPTH). It provides push/pop/full/empty/err and the top-of-stack output, and is instantiated once.

Test Plan:
- Reset then idle: flags=0, stk_empty=1, res_valid=0, br_ready=1, stk_err=0.
- flag_we with alu_result=16'h0000, v=0, c=1, then br_cond=0 (EQ) next cycle: flags=4'b0101, res_valid=1, res_taken=1 one cycle after acceptance.
- FWD_EN=1: same-cycle flag_we (result 16'h8000, v=0) and br_cond=3 (LT): res_taken=1. Repeat with FWD_EN=0 and prior flags=0: res_taken=0.
- Backpressure: res_ready=0 for 3 cycles: br_ready=0, res_taken stable. Then res_ready=1 with a new br_valid: back-to-back results with no bubble.
- Stack sequence:
  - Set flags 4'b1000, push; set flags 4'b0100, push; pop gives flags=4'b0100, then pop gives flags=4'b1000, stk_empty=1.
  - A third pop sets stk_err=1 and leaves flags unchanged.
- Fill the stack to 4, push again: stk_full=1, stk_err=1, count unchanged. Then assert pop with flag_we in the same cycle: popped value wins. Assert rst_n=0: all outputs return to their reset values.
